// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: PC, instruction-memory and decode signals of the fetch sequencer.
interface fetch_sequencer_if;
    logic [15:0] pc_in;
    logic        redirect;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] fetch_pc;
    logic        pc_adv;
    logic        fault;
    logic [2:0]  state;
    modport master (
        input  pc_in, redirect, halt, imem_ack, imem_data, instr_ready,
        output imem_req, imem_addr, instr, instr_valid, fetch_pc, pc_adv, fault, state
    );
    modport slave (
        output pc_in, redirect, halt, imem_ack, imem_data, instr_ready,
        input  imem_req, imem_addr, instr, instr_valid, fetch_pc, pc_adv, fault, state
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: issues one req/ack fetch per instruction, holds it for decode,
// flushes wrong-path fetches on redirect and raises a sticky fault on memory timeout.
module fetch_sequencer #(
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE = 3'd0, SETUP = 3'd1, FETCH = 3'd2, HOLD = 3'd3, DRAIN = 3'd4} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        r_state, w_next;
    logic          r_req, r_fault;
    logic [15:0]   r_addr, r_instr, r_fetch_pc;
    logic [CW-1:0] r_cnt;
    logic          w_busy, w_ack, w_timeout;
    assign w_busy    = (r_state == FETCH) || (r_state == DRAIN);
    assign w_ack     = w_busy & bus.imem_ack;
    // the last allowed request cycle still accepts an ack; only a miss there faults
    assign w_timeout = w_busy & ~bus.imem_ack & (r_cnt == CW'(TIMEOUT - 1));
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (!bus.halt && !r_fault) ? SETUP : IDLE;
            SETUP:   w_next = FETCH;
            FETCH:   w_next = w_ack ? (bus.redirect ? SETUP : HOLD) : w_timeout ? IDLE : bus.redirect ? DRAIN : FETCH;
            DRAIN:   w_next = w_ack ? SETUP : w_timeout ? IDLE : DRAIN;
            HOLD:    w_next = bus.redirect ? SETUP : bus.instr_ready ? (bus.halt ? IDLE : SETUP) : HOLD;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_instr    <= '0;
            r_fetch_pc <= '0;
            r_fault    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next;
            r_req   <= (w_next == FETCH) || (w_next == DRAIN);
            if (r_state == SETUP) begin
                r_addr <= bus.pc_in;
                r_cnt  <= '0;
            end else if (w_busy && !bus.imem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == FETCH && bus.imem_ack && !bus.redirect) begin
                r_instr    <= bus.imem_data;
                r_fetch_pc <= r_addr;
            end
            if (w_timeout)
                r_fault <= 1'b1;
        end
    end
    assign bus.imem_req    = r_req;
    assign bus.imem_addr   = r_addr;
    assign bus.instr       = r_instr;
    assign bus.fetch_pc    = r_fetch_pc;
    assign bus.instr_valid = (r_state == HOLD);
    assign bus.pc_adv      = (r_state == HOLD) & bus.instr_ready & ~bus.redirect;
    assign bus.fault       = r_fault;
    assign bus.state       = r_state;
endmodule
